// File: rtl/bus_slave_port_if.sv
// Serial bus connection between the arbiter (master side) and one slave endpoint.
//   address_in/data_in/valid_in/write_en : serial frame from the arbiter
//   bus_ready                            : bus currently routed to this slave
//   ready/data_out/valid_out/hold        : slave status, serial read data, split request
interface bus_slave_port_if;
  logic address_in;
  logic data_in;
  logic valid_in;
  logic write_en;
  logic bus_ready;
  logic ready;
  logic data_out;
  logic valid_out;
  logic hold;

  modport master (
    output address_in, data_in, valid_in, write_en, bus_ready,
    input  ready, data_out, valid_out, hold
  );

  modport slave (
    input  address_in, data_in, valid_in, write_en, bus_ready,
    output ready, data_out, valid_out, hold
  );
endinterface

// File: rtl/bus_slave_port.sv
// Slave-side endpoint of the serial bus: deserialises address/write data, accesses a
// local register-array memory and serialises read data back, raising hold (split
// request) while waiting out the read latency.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport of bus_slave_port_if (frame in, status/read data out)
//   state      : current FSM state, exported for test
module bus_slave_port #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 4,
  parameter bit          SPLIT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  bus_slave_port_if.slave  bus,
  output logic [2:0]       state
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned ACW   = $clog2(ADDR_WIDTH + 1);
  localparam int unsigned DCW   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned LCW   = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RLAT  = 3'd4,
    S_RDATA = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [ACW-1:0]        acnt_q;
  logic [DCW-1:0]        dcnt_q;
  logic [LCW-1:0]        lcnt_q;
  logic                  we_q;
  logic                  data_out_q;
  logic                  valid_out_q;
  logic                  hold_q;

  logic                  addr_shift;
  logic                  wdata_shift;
  logic                  tx_load;
  logic                  launch;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address including the bit arriving this cycle; used to fetch read data on RLAT entry.
  logic [ADDR_WIDTH-1:0] addr_full;
  assign addr_full = {addr_q[ADDR_WIDTH-2:0], bus.address_in};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d     = state_q;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    tx_load     = 1'b0;
    launch      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          addr_shift = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.valid_in) begin
          addr_shift = 1'b1;
          if (acnt_q == ACW'(ADDR_WIDTH - 1)) begin
            state_d = we_q ? S_WDATA : S_RLAT;
            tx_load = !we_q;
          end
        end
      end
      S_WDATA: begin
        if (bus.valid_in) begin
          wdata_shift = 1'b1;
          if (dcnt_q == DCW'(DATA_WIDTH - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_RLAT: begin
        // The first bit is launched on the RLAT exit edge so it appears on entry to RDATA.
        if (lcnt_q == LCW'(READ_LATENCY - 1)) begin
          state_d = S_RDATA;
          launch  = bus.bus_ready;
        end
      end
      S_RDATA: begin
        if (dcnt_q == DCW'(DATA_WIDTH)) state_d = S_IDLE;
        else                            launch  = bus.bus_ready;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift registers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      acnt_q      <= '0;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      we_q        <= 1'b0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      if (addr_shift) begin
        addr_q <= addr_full;
        acnt_q <= (state_q == S_IDLE) ? ACW'(1) : acnt_q + ACW'(1);
      end
      if (state_q == S_IDLE && bus.valid_in) we_q <= bus.write_en;
      if (wdata_shift) wdata_q <= {wdata_q[DATA_WIDTH-2:0], bus.data_in};
      if (tx_load) tx_q <= mem[addr_full];
      if (launch) begin
        data_out_q <= tx_q[DATA_WIDTH-1];
        tx_q       <= tx_q << 1;
      end
      // dcnt counts received write bits, then sent read bits; cleared on return to IDLE.
      if (wdata_shift || launch) dcnt_q <= dcnt_q + DCW'(1);
      else if (state_d == S_IDLE) dcnt_q <= '0;
      lcnt_q      <= (state_q == S_RLAT) ? lcnt_q + LCW'(1) : '0;
      valid_out_q <= launch;
      hold_q      <= SPLIT_EN && (state_d == S_RLAT);
    end
  end

  // Memory array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[addr_q] <= wdata_q;
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.hold      = hold_q;
  assign state         = state_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Self-checking bench for bus_slave_port: a split-enabled and a split-disabled instance
// receive identical stimulus; read results are scoreboarded against a memory model.
module tb_bus_slave_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state0, state1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_slave_port_if b0 ();
  bus_slave_port_if b1 ();

  assign b1.address_in = b0.address_in;
  assign b1.data_in    = b0.data_in;
  assign b1.valid_in   = b0.valid_in;
  assign b1.write_en   = b0.write_en;
  assign b1.bus_ready  = b0.bus_ready;

  bus_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(4), .SPLIT_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .state(state0));
  bus_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(4), .SPLIT_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .state(state1));

  typedef struct {
    logic [7:0] data;
    int         start;
    int         gaps;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [int];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Serial address, MSB first, with an optional valid_in gap after bit gap_at.
  task automatic send_addr(input bit we, input logic [11:0] a, input int gap_at, input int gap_len);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      b0.valid_in   = 1'b1;
      b0.address_in = a[11-i];
      b0.write_en   = (i == 0) ? we : ~we;
      b0.data_in    = 1'($urandom_range(1));
      if (i == gap_at) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
          b0.valid_in   = 1'b0;
          b0.address_in = ~a[11-i];
        end
      end
    end
  endtask

  // Wait for ready; optionally stall bus_ready or toggle ignored inputs meanwhile.
  task automatic wait_idle(input bit stall, input bit toggle, output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      n = k;
      if (stall && k == 7) b0.bus_ready = 1'b0;
      if (stall && k == 9) b0.bus_ready = 1'b1;
      if (b0.ready) begin
        b0.valid_in = 1'b0;
        return;
      end
      b0.valid_in   = toggle ? 1'($urandom_range(1)) : 1'b0;
      b0.address_in = 1'($urandom_range(1));
      b0.data_in    = 1'($urandom_range(1));
    end
    check("idle_timeout", int'(b0.ready), 1);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int ga, input int gd,
                          input int abort_at);
    int n;
    send_addr(1'b1, a, ga, 3);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b0.valid_in   = 1'b1;
      b0.data_in    = d[7-i];
      b0.address_in = 1'($urandom_range(1));
      if (i == abort_at) begin
        @(posedge clk); #1;
        b0.valid_in = 1'b0;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", int'(state0), 0);
        check("abort_ready", int'(b0.ready), 1);
        return;
      end
      if (i == gd) begin
        repeat (3) begin
          @(posedge clk); #1;
          b0.valid_in = 1'b0;
          b0.data_in  = ~d[7-i];
        end
      end
    end
    wait_idle(1'b0, 1'b0, n);
    check("wr_ready_lat", n, 2);
    model[int'(a)] = d;
  endtask

  task automatic do_read(input logic [11:0] a, input bit stall, input bit toggle);
    int   n;
    exp_t e;
    send_addr(1'b0, a, -1, 0);
    e.data  = model[int'(a)];
    e.start = cyc + 5;
    e.gaps  = stall ? 2 : 0;
    sb.push_back(e);
    wait_idle(stall, toggle, n);
    check("rd_ready_lat", n, stall ? 15 : 13);
  endtask

  // Output monitor: assembles serial read data and compares against the scoreboard.
  bit         in_frame = 1'b0;
  bit         pend = 1'b0;
  int         bits = 0, gaps = 0, start = 0, hcnt0 = 0, hcnt1 = 0, diffs = 0;
  logic [7:0] rx = '0;
  exp_t       me;

  always @(negedge clk) begin
    if (!reset) begin
      if (pend) begin
        check("ready_after", int'(b0.ready), 1);
        pend = 1'b0;
      end
      if (b0.hold) hcnt0++;
      if (b1.hold) hcnt1++;
      if (b0.valid_out !== b1.valid_out || b0.data_out !== b1.data_out) diffs++;
      if (b0.valid_out) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          bits     = 0;
          gaps     = 0;
          start    = cyc;
        end
        rx = {rx[6:0], b0.data_out};
        bits++;
        if (bits == 8) begin
          in_frame = 1'b0;
          pend     = 1'b1;
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            me = sb.pop_front();
            check("rd_data", int'(rx), int'(me.data));
            check("rd_start", start, me.start);
            check("rd_gaps", gaps, me.gaps);
            check("hold_split", hcnt0, 4);
            check("hold_nosplit", hcnt1, 0);
            check("inst_match", diffs, 0);
            check("ready_last", int'(b0.ready), 0);
          end
          hcnt0 = 0;
          hcnt1 = 0;
          diffs = 0;
        end
      end else if (in_frame) begin
        gaps++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    b0.valid_in   = 1'b0;
    b0.address_in = 1'b0;
    b0.data_in    = 1'b0;
    b0.write_en   = 1'b0;
    b0.bus_ready  = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state0), 0);
    check("rst_ready", int'(b0.ready), 1);
    check("rst_valid_out", int'(b0.valid_out), 0);
    check("rst_hold", int'(b0.hold), 0);
    check("rst_data_out", int'(b0.data_out), 0);
    reset = 1'b0;

    do_write(12'h123, 8'hA5, -1, -1, -1);
    do_read(12'h123, 1'b0, 1'b0);

    do_write(12'h001, 8'h3C, 5, 3, -1);
    do_read(12'h001, 1'b0, 1'b0);

    do_read(12'h123, 1'b1, 1'b0);

    do_write(12'h050, 8'h11, -1, -1, -1);
    do_write(12'h050, 8'hEE, -1, -1, 3);
    do_read(12'h050, 1'b0, 1'b0);

    do_write(12'hFFF, 8'hFF, -1, -1, -1);
    do_write(12'h000, 8'h00, -1, -1, -1);
    do_read(12'hFFF, 1'b0, 1'b1);
    do_read(12'h000, 1'b0, 1'b1);
    do_read(12'h001, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
